// File: rtl/vga_scan.sv
// -----------------------------------------------------------------------------
// vga_scan
//
// Raster timing generator and registered VGA output stage for the Tetris
// display path. Sweeps an SVGA 800x600@72 Hz raster (by default) at one pixel
// per CLOCK_50 cycle and presents the current col/row to the pixel generator.
// The generator returns a 24-bit colour combinationally in the same cycle.
// That colour is registered onto the DAC pins together with sync and blank,
// so all VGA_* pins carry one cycle of latency and stay mutually aligned.
//
// Optional feature macro:
//   VGA_BORDER_TEST_EN - when defined, visible pixels on the outer frame
//                        (first/last column, first/last row) are forced to
//                        white as a monitor alignment aid.
//
// Ports:
//   CLOCK_50       in   1   pixel clock; all state updates on rising edge
//   reset          in   1   asynchronous, active-high
//   pixel_red      in   8   red for the current col/row
//   pixel_green    in   8   green for the current col/row
//   pixel_blue     in   8   blue for the current col/row
//   col            out  11  horizontal count, 0..H_TOTAL-1
//   row            out  11  vertical count, 0..V_TOTAL-1
//   visible        out  1   col < H_VISIBLE and row < V_VISIBLE
//   frame_start    out  1   high while col == 0 and row == 0
//   VGA_R/G/B      out  8   registered colour to DAC (0 during blanking)
//   VGA_HS         out  1   registered horizontal sync (asserted = HS_POL)
//   VGA_VS         out  1   registered vertical sync (asserted = VS_POL)
//   VGA_BLANK_N    out  1   registered, low during blanking
//
// H_TOTAL and V_TOTAL must both be <= 2048 (11-bit unsigned counters).
// -----------------------------------------------------------------------------
module vga_scan #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BACK    = 64,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 23,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  pixel_red,
  input  logic [7:0]  pixel_green,
  input  logic [7:0]  pixel_blue,
  output logic [10:0] col,
  output logic [10:0] row,
  output logic        visible,
  output logic        frame_start,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Boundaries are held at 12 bits so that an end-of-region value of 2048
  // (legal when a total is exactly 2048) does not wrap to zero.
  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS        = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS        = 12'(V_VISIBLE);
  localparam logic [11:0] H_SYNC_START = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] H_SYNC_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [11:0] V_SYNC_START = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] V_SYNC_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [10:0] h_count;
  logic [10:0] v_count;
  logic [11:0] h_ext;
  logic [11:0] v_ext;
  logic        h_last;
  logic        v_last;

  assign h_ext  = {1'b0, h_count};
  assign v_ext  = {1'b0, v_count};
  assign h_last = (h_ext == H_LAST);
  assign v_last = (v_ext == V_LAST);

  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_last) begin
      // Line wrap; the frame wrap shares this same cycle at (H_LAST, V_LAST).
      h_count <= '0;
      v_count <= v_last ? 11'd0 : v_count + 11'd1;
    end else begin
      h_count <= h_count + 11'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Coordinate outputs and region decode (combinational from the counters)
  // ---------------------------------------------------------------------------
  logic hsync_region;
  logic vsync_region;

  assign col          = h_count;
  assign row          = v_count;
  assign visible      = (h_ext < H_VIS) && (v_ext < V_VIS);
  assign frame_start  = (h_count == 11'd0) && (v_count == 11'd0);
  assign hsync_region = (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
  // Depends only on v_count, so VS switches on the h_count == 0 boundary.
  assign vsync_region = (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);

  // ---------------------------------------------------------------------------
  // Pixel source selection
  // ---------------------------------------------------------------------------
  rgb_t pix_in;
  rgb_t pix_src;

  assign pix_in = '{r: pixel_red, g: pixel_green, b: pixel_blue};

`ifdef VGA_BORDER_TEST_EN
  localparam logic [11:0] H_VIS_LAST = 12'(H_VISIBLE - 1);
  localparam logic [11:0] V_VIS_LAST = 12'(V_VISIBLE - 1);

  logic on_border;

  assign on_border = (h_ext == 12'd0) || (h_ext == H_VIS_LAST) ||
                     (v_ext == 12'd0) || (v_ext == V_VIS_LAST);

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it holding a value (no inferred latch).
  always_comb begin
    pix_src = pix_in;
    if (on_border) begin
      pix_src = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    end
  end
`else
  assign pix_src = pix_in;
`endif

  // ---------------------------------------------------------------------------
  // Registered output stage: colour, sync and blank share one cycle of delay.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK_N <= 1'b0;
    end else begin
      VGA_R       <= visible ? pix_src.r : 8'h00;
      VGA_G       <= visible ? pix_src.g : 8'h00;
      VGA_B       <= visible ? pix_src.b : 8'h00;
      VGA_HS      <= hsync_region ? HS_POL : ~HS_POL;
      VGA_VS      <= vsync_region ? VS_POL : ~VS_POL;
      VGA_BLANK_N <= visible;
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
// -----------------------------------------------------------------------------
// tb_vga_scan
//
// Self-checking bench for vga_scan. Horizontal timing uses the SVGA defaults;
// the vertical raster is shortened (20 visible, 3 front, 2 sync, 3 back lines)
// so that complete frames fit in a short run.
//
// A free-running scoreboard models the raster independently: each cycle it
// pushes the expected registered outputs for the current coordinate and
// pops/compares them one cycle later. A table of hand-derived vectors and a
// few hand-written sequences cover reset, sync edges, blanking, wrap and
// mid-frame reset.
// -----------------------------------------------------------------------------
module tb_vga_scan;

  localparam int HV = 800, HF = 56, HSW = 120, HB = 64;
  localparam int VV = 20,  VF = 3,  VSW = 2,   VB = 3;
  localparam int H_TOTAL = HV + HF + HSW + HB;   // 1040
  localparam int V_TOTAL = VV + VF + VSW + VB;   // 28
  localparam int FRAME   = H_TOTAL * V_TOTAL;    // 29120
  localparam int GOTO_LIMIT = 40000;

`ifdef VGA_BORDER_TEST_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bn;
  } out_t;

  typedef struct {
    int          c;
    int          r;
    logic [23:0] pix;
    out_t        exp;
  } vec_t;

  localparam out_t RESET_OUT = '{r: 8'h00, g: 8'h00, b: 8'h00,
                                 hs: 1'b0, vs: 1'b0, bn: 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pixel_red, pixel_green, pixel_blue;
  logic [10:0] col, row;
  logic        visible, frame_start;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;

  int n_tests = 0;
  int n_fail  = 0;

  vga_scan #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b1),  .VS_POL(1'b1)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .pixel_red  (pixel_red),
    .pixel_green(pixel_green),
    .pixel_blue (pixel_blue),
    .col        (col),
    .row        (row),
    .visible    (visible),
    .frame_start(frame_start),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N)
  );

  always #10 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model of the registered outputs for one coordinate.
  // ---------------------------------------------------------------------------
  function automatic out_t model_out(input int h, input int v, input logic [23:0] pix);
    out_t o;
    bit   vis;
    bit   brd;
    vis  = (h < HV) && (v < VV);
    brd  = BORDER && ((h == 0) || (h == HV - 1) || (v == 0) || (v == VV - 1));
    o.r  = vis ? (brd ? 8'hFF : pix[23:16]) : 8'h00;
    o.g  = vis ? (brd ? 8'hFF : pix[15:8])  : 8'h00;
    o.b  = vis ? (brd ? 8'hFF : pix[7:0])   : 8'h00;
    o.hs = (h >= HV + HF) && (h < HV + HF + HSW);
    o.vs = (v >= VV + VF) && (v < VV + VF + VSW);
    o.bn = vis;
    return o;
  endfunction

  function automatic out_t dut_out();
    return {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [23:0] p);
    {pixel_red, pixel_green, pixel_blue} = p;
  endtask

  // Step until the DUT reaches (c, r); bounded so a stuck counter cannot hang.
  task automatic goto(input int c, input int r);
    int n;
    n = 0;
    while (!(col == c && row == r) && n < GOTO_LIMIT) begin
      tick();
      n++;
    end
    if (n >= GOTO_LIMIT) begin
      n_tests++;
      n_fail++;
      $display("FAIL goto_timeout: stuck at (%0d,%0d), wanted (%0d,%0d)", col, row, c, r);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: sampled on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  out_t  sb_q[$];
  int    mh = 0, mv = 0;
  int    sb_cycles = 0;
  int    sb_errs   = 0;
  string sb_first  = "";

  always @(negedge clk) begin
    out_t e;
    out_t a;
    bit   ok;
    a = dut_out();
    if (reset) begin
      mh = 0;
      mv = 0;
      sb_q.delete();
      sb_q.push_back(RESET_OUT);
      ok = (a === RESET_OUT) && (col === 11'd0) && (row === 11'd0);
      if (!ok && sb_errs++ == 0)
        sb_first = $sformatf("in reset: out=%h col=%0d row=%0d", a, col, row);
    end else begin
      sb_cycles++;
      if (sb_q.size() == 0) begin
        if (sb_errs++ == 0) sb_first = "scoreboard underflow";
      end else begin
        e = sb_q.pop_front();
        if (a !== e && sb_errs++ == 0)
          sb_first = $sformatf("at (%0d,%0d) out=%h exp=%h", mh, mv, a, e);
      end
      ok = (col === 11'(mh)) && (row === 11'(mv)) &&
           (visible === ((mh < HV) && (mv < VV))) &&
           (frame_start === ((mh == 0) && (mv == 0)));
      if (!ok && sb_errs++ == 0)
        sb_first = $sformatf("coords exp (%0d,%0d) got (%0d,%0d) vis=%b fs=%b",
                             mh, mv, col, row, visible, frame_start);
      sb_q.push_back(model_out(mh, mv, {pixel_red, pixel_green, pixel_blue}));
      mh++;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv++;
        if (mv == V_TOTAL) mv = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam int NV = 17;
  vec_t tbl [NV];

  function automatic vec_t mk(input int c, input int r, input logic [23:0] pix,
                              input logic [23:0] rgb, input bit hs, input bit vs,
                              input bit bn);
    vec_t v;
    v.c   = c;
    v.r   = r;
    v.pix = pix;
    v.exp = {rgb, hs, vs, bn};
    return v;
  endfunction

  initial begin
    int fs_at, rises, hs_high, vs_high, run, min_run, max_run;
    bit prev_hs;

    // Expected outputs one cycle after (c, r) is presented with pix.
    tbl[0]  = mk(5,    0,  24'h123456, BORDER ? 24'hFFFFFF : 24'h123456, 0, 0, 1);
    tbl[1]  = mk(799,  0,  24'hFFFFFF, 24'hFFFFFF, 0, 0, 1);
    tbl[2]  = mk(800,  0,  24'hFFFFFF, 24'h000000, 0, 0, 0);
    tbl[3]  = mk(855,  0,  24'hFFFFFF, 24'h000000, 0, 0, 0);
    tbl[4]  = mk(856,  0,  24'hFFFFFF, 24'h000000, 1, 0, 0);
    tbl[5]  = mk(975,  0,  24'hFFFFFF, 24'h000000, 1, 0, 0);
    tbl[6]  = mk(976,  0,  24'hFFFFFF, 24'h000000, 0, 0, 0);
    tbl[7]  = mk(1039, 0,  24'hFFFFFF, 24'h000000, 0, 0, 0);
    tbl[8]  = mk(0,    1,  24'hA5A5A5, BORDER ? 24'hFFFFFF : 24'hA5A5A5, 0, 0, 1);
    tbl[9]  = mk(1,    1,  24'h000000, 24'h000000, 0, 0, 1);
    tbl[10] = mk(799,  5,  24'h000000, BORDER ? 24'hFFFFFF : 24'h000000, 0, 0, 1);
    tbl[11] = mk(100,  19, 24'h00FF00, BORDER ? 24'hFFFFFF : 24'h00FF00, 0, 0, 1);
    tbl[12] = mk(100,  20, 24'hFFFFFF, 24'h000000, 0, 0, 0);
    tbl[13] = mk(0,    23, 24'hFFFFFF, 24'h000000, 0, 1, 0);
    tbl[14] = mk(1039, 24, 24'hFFFFFF, 24'h000000, 0, 1, 0);
    tbl[15] = mk(0,    25, 24'hFFFFFF, 24'h000000, 0, 0, 0);
    tbl[16] = mk(900,  26, 24'hFFFFFF, 24'h000000, 1, 0, 0);

    // --- Reset state and release -------------------------------------------
    reset = 1'b1;
    set_pix(24'h000000);
    repeat (3) tick();
    check("rst_col",         32'(col), 0);
    check("rst_row",         32'(row), 0);
    check("rst_visible",     32'(visible), 1);
    check("rst_frame_start", 32'(frame_start), 1);
    check("rst_outputs",     32'(dut_out()), 32'(RESET_OUT));

    set_pix(24'hF00000);
    reset = 1'b0;
    check("release_frame_start", 32'(frame_start), 1);
    check("release_col",         32'(col), 0);
    tick();
    check("cyc1_col",     32'(col), 1);
    check("cyc1_fs",      32'(frame_start), 0);
    check("cyc1_red",     32'(VGA_R), BORDER ? 32'hFF : 32'hF0);
    check("cyc1_blank_n", 32'(VGA_BLANK_N), 1);
    tick();
    check("cyc2_col",     32'(col), 2);

    // --- Table-driven vectors ----------------------------------------------
    for (int i = 0; i < NV; i++) begin
      goto(tbl[i].c, tbl[i].r);
      set_pix(tbl[i].pix);
      tick();
      check($sformatf("vec%0d_(%0d,%0d)", i, tbl[i].c, tbl[i].r),
            32'(dut_out()), 32'(tbl[i].exp));
    end

    // --- Frame wrap --------------------------------------------------------
    goto(H_TOTAL - 1, V_TOTAL - 1);
    tick();
    check("wrap_col", 32'(col), 0);
    check("wrap_row", 32'(row), 0);
    check("wrap_fs",  32'(frame_start), 1);

    // --- One full frame with random pixels ---------------------------------
    fs_at = -1; rises = 0; hs_high = 0; vs_high = 0;
    run = 0; min_run = 1 << 30; max_run = 0;
    prev_hs = VGA_HS;
    for (int i = 1; i <= FRAME; i++) begin
      set_pix(24'($urandom));
      tick();
      if (frame_start && fs_at < 0) fs_at = i;
      if (VGA_HS) begin
        hs_high++;
        run++;
        if (!prev_hs) rises++;
      end else if (prev_hs) begin
        if (run < min_run) min_run = run;
        if (run > max_run) max_run = run;
        run = 0;
      end
      if (VGA_VS) vs_high++;
      prev_hs = VGA_HS;
    end
    check("frame_period",  32'(fs_at), FRAME);
    check("hs_pulses",     32'(rises), V_TOTAL);
    check("hs_high_total", 32'(hs_high), V_TOTAL * HSW);
    check("hs_min_width",  32'(min_run), HSW);
    check("hs_max_width",  32'(max_run), HSW);
    check("vs_high_total", 32'(vs_high), VSW * H_TOTAL);

    // --- Mid-frame reset ---------------------------------------------------
    set_pix(24'hFFFFFF);
    goto(500, 10);
    check("pre_reset_red", 32'(VGA_R), 32'hFF);
    reset = 1'b1;
    #1;
    check("async_rst_col",     32'(col), 0);
    check("async_rst_row",     32'(row), 0);
    check("async_rst_outputs", 32'(dut_out()), 32'(RESET_OUT));
    repeat (3) tick();
    check("held_rst_col", 32'(col), 0);
    reset = 1'b0;
    check("resume_col0", 32'(col), 0);
    check("resume_row0", 32'(row), 0);
    tick();
    check("resume_col1",   32'(col), 1);
    check("resume_row1",   32'(row), 0);
    check("resume_red",    32'(VGA_R), 32'hFF);
    check("resume_blankn", 32'(VGA_BLANK_N), 1);
    tick();

    // --- Scoreboard verdict ------------------------------------------------
    check("sb_active", 32'(sb_cycles > 50000), 1);
    n_tests++;
    if (sb_errs != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d bad cycles, expected 0; first %s", sb_errs, sb_first);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan.md
# vga_scan

Raster timing generator and video output stage for the Tetris display path. It sweeps an SVGA 800x600@72 Hz raster at one pixel per CLOCK_50 cycle and presents the current `col`/`row` to the pixel generator (the `tetris` top). It samples the 24-bit colour that the generator returns combinationally and drives the registered VGA DAC pins and sync pulses, so that colour and sync stay aligned.

## Interface
Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BACK, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 23, vertical back porch (lines)
- HS_POL, 1, asserted level of VGA_HS
- VS_POL, 1, asserted level of VGA_VS

Ports:
- CLOCK_50  input  1  pixel clock, 50 MHz; all state on rising edge
- reset  input  1  asynchronous, active-high
- pixel_red  input  8  red from the pixel generator for the current col/row
- pixel_green  input  8  green from the pixel generator
- pixel_blue  input  8  blue from the pixel generator
- col  output  11  current horizontal count, 0..H_TOTAL-1
- row  output  11  current vertical count, 0..V_TOTAL-1
- visible  output  1  high when col < H_VISIBLE and row < V_VISIBLE
- frame_start  output  1  one-cycle pulse when col==0 and row==0
- VGA_R  output  8  registered red to DAC
- VGA_G  output  8  registered green to DAC
- VGA_B  output  8  registered blue to DAC
- VGA_HS  output  1  registered horizontal sync
- VGA_VS  output  1  registered vertical sync
- VGA_BLANK_N  output  1  registered, low during blanking

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (1040 by default); V_TOTAL is the vertical equivalent (666 by default). Both must be ≤ 2048; counters are 11 bits and unsigned.
- h_count increments every cycle. At H_TOTAL-1 it wraps to 0, and v_count increments in the same cycle. v_count wraps from V_TOTAL-1 to 0 on that same h wrap.
- col = h_count and row = v_count, taken directly from the registers. They keep counting through blanking; the generator must tolerate off-screen coordinates.
- Horizontal sync region: H_VISIBLE+H_FRONT ≤ h_count < H_VISIBLE+H_FRONT+H_SYNC (856..975 by default). Vertical sync region: V_VISIBLE+V_FRONT ≤ v_count < V_VISIBLE+V_FRONT+V_SYNC (637..642 by default). VS asserts and deasserts aligned with h_count==0.
- Output stage runs every cycle:
  - VGA_R/G/B ← visible ? pixel_* : 0
  - VGA_HS ← hsync_region ? HS_POL : ~HS_POL; VGA_VS uses the same rule with VS_POL
  - VGA_BLANK_N ← visible
- No handshake. The pixel generator must be purely combinational from col/row, with settle time under one cycle.

## Timing
- Reset values:
  - h_count = 0, v_count = 0, so col = row = 0, visible = 1, frame_start = 1
  - VGA_R/G/B = 0
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL
  - VGA_BLANK_N = 0
- The first clock edge after reset deasserts produces h_count = 1. The frame_start pulse at (0,0) is visible for the whole reset-release cycle.
- Latency: pixel values for (col,row) presented in cycle t appear on VGA_* in cycle t+1. Sync and blank carry the same one-cycle delay, so the pins are mutually aligned.
- frame_start recurs every H_TOTAL×V_TOTAL cycles (692 640 by default). The line period is H_TOTAL cycles.
- Reset asserted mid-frame immediately forces all registers to their reset values, with no partial-line completion. The frame restarts from (0,0).
- The h and v wraps at (H_TOTAL-1, V_TOTAL-1) happen in the same cycle; the next state is (0,0).

## Configuration
- VGA_BORDER_TEST_EN defined: while visible, any pixel with col==0, col==H_VISIBLE-1, row==0 or row==V_VISIBLE-1 drives 8'hFF on R/G/B regardless of pixel_*. This provides a monitor alignment frame. All other pixels pass through unchanged.
- Undefined: the border logic is absent, and R/G/B follow pixel_* only.

## Test plan
- Reset release with pixel_* = 24'hF00000: col/row step 0,1,2,… At cycle 1 VGA_R = F0 and VGA_BLANK_N = 1. VGA_HS first asserts (1) in the cycle after col==856 and deasserts in the cycle after col==976.
- Run one full frame: exactly 666 HS pulses of 120 cycles each; VS high for 6 lines (6240 cycles); frame_start period 692 640.
- Hold pixel_* = 24'hFFFFFF: VGA_R/G/B = 0 in every cycle following col ≥ 800 or row ≥ 600, and VGA_BLANK_N = 0 in those cycles.
- Assert reset at col = 500, row = 300 for 3 cycles: outputs immediately take their reset values, and the count resumes at (0,0) followed by (1,0).
- Wrap check: at col = 1039, row = 665, the next cycle gives col = 0, row = 0 and frame_start = 1.
- With VGA_BORDER_TEST_EN defined and pixel_* = 0: VGA_R/G/B = FF for col 0 and 799 on row 0..599, and for rows 0 and 599. Pixel (1,1) = 0.
